// File: rtl/linie_pkg.sv
// Shared types for the line-follower controller: FSM states, motor direction codes,
// circuit selection codes and the last-side memory.
package linie_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FOLLOW   = 3'd1,
        ST_SEARCH_R = 3'd2,
        ST_SEARCH_L = 3'd3,
        ST_FINISH   = 3'd4,
        ST_HALT     = 3'd5
    } stare_t;

    typedef enum logic {
        PARTE_DREAPTA = 1'b0,
        PARTE_STANGA  = 1'b1
    } parte_t;

    localparam logic [1:0] DIR_BRAKE = 2'b00;
    localparam logic [1:0] DIR_FWD   = 2'b01;
    localparam logic [1:0] DIR_REV   = 2'b10;

    localparam logic [1:0] CIRC_IDLE      = 2'b00;
    localparam logic [1:0] CIRC_DREPT     = 2'b01;
    localparam logic [1:0] CIRC_CURBE     = 2'b10;
    localparam logic [1:0] CIRC_ANDURANTA = 2'b11;

endpackage

// File: rtl/control_urmarire_linie_sincron.sv
// Two-flop synchroniser for the asynchronous reflective sensor vector.
module sincron_senzori #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] senzori_i,
    output logic [N-1:0] senzori_o
);

    logic [N-1:0] meta_q;
    logic [N-1:0] sinc_q;

    // metastability stage followed by the stable stage
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= {N{1'b0}};
            sinc_q <= {N{1'b0}};
        end else begin
            meta_q <= senzori_i;
            sinc_q <= meta_q;
        end
    end

    assign senzori_o = sinc_q;

endmodule

// File: rtl/control_urmarire_linie.sv
// Line-follower controller: sensor sync, follow/search/finish FSM, debounced lap count, motor outputs.
// Optional macro SOFT_START_EN: duty words ramp up by DC_MAX/16 every 1024 clk instead of jumping.
module control_urmarire_linie
    import linie_pkg::*;
#(
    parameter int N_SENZORI = 5,
    parameter int DC_W      = 13,
    parameter int DC_MAX    = 2457,
    parameter int DC_CURBA  = 1228,
    parameter int LAP_W     = 8,
    parameter int DEB_CYC   = 1000,
    parameter int SEARCH_TO = 50000000,
    parameter int LAP_CURBE = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_SENZORI-1:0] senzori,
    input  logic [1:0]           circuit,
    output logic [1:0]           directie_driverA,
    output logic [1:0]           directie_driverB,
    output logic [DC_W-1:0]      factor_dc_driverA,
    output logic [DC_W-1:0]      factor_dc_driverB,
    output logic                 semnal_dreapta,
    output logic                 semnal_stanga,
    output logic                 stop,
    output logic [LAP_W-1:0]     count_ture,
    output logic [2:0]           stare
);

    localparam int MIJ   = N_SENZORI / 2;
    localparam int DEB_W = $clog2(DEB_CYC + 1);
    localparam int TO_W  = $clog2(SEARCH_TO + 1);

    localparam logic [DC_W-1:0]  DC_ZERO   = {DC_W{1'b0}};
    localparam logic [DC_W-1:0]  DC_DREPT  = DC_W'(DC_MAX);
    localparam logic [DC_W-1:0]  DC_INT    = DC_W'(DC_CURBA);
    localparam logic [DEB_W-1:0] DEB_ULTIM = DEB_W'(DEB_CYC - 1);
    localparam logic [DEB_W-1:0] DEB_UNU   = DEB_W'(1);
    localparam logic [TO_W-1:0]  TO_ULTIM  = TO_W'(SEARCH_TO - 1);
    localparam logic [TO_W-1:0]  TO_UNU    = TO_W'(1);
    localparam logic [LAP_W-1:0] LAP_UNU   = LAP_W'(1);
    localparam logic [LAP_W-1:0] LAP_PLIN  = {LAP_W{1'b1}};
    localparam logic [LAP_W-1:0] LIM_CURBE = LAP_W'(LAP_CURBE);

    logic [N_SENZORI-1:0] sinc_s;
    logic centru_s, int_dr_s, int_st_s, sosire_s, linie_s, pierdut_s, deb_gata_s, limita_s;

    stare_t           stare_q, stare_d;
    parte_t           parte_q, parte_d;
    logic [DEB_W-1:0] deb_q, deb_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [LAP_W-1:0] count_q, count_d;
    logic [1:0]       dir_a_q, dir_a_d, dir_b_q, dir_b_d;
    logic [DC_W-1:0]  dc_a_q, dc_a_d, dc_b_q, dc_b_d;
    logic [DC_W-1:0]  tinta_a_s, tinta_b_s;
    logic             sdr_q, sst_q, stop_q;

    sincron_senzori #(.N(N_SENZORI)) u_sincron (
        .clk       (clk),
        .reset     (reset),
        .senzori_i (senzori),
        .senzori_o (sinc_s)
    );

    assign centru_s   = sinc_s[MIJ];
    assign int_dr_s   = |sinc_s[MIJ-1:1];
    assign int_st_s   = |sinc_s[N_SENZORI-2:MIJ+1];
    assign sosire_s   = sinc_s[0] & sinc_s[N_SENZORI-1];
    assign linie_s    = centru_s | int_dr_s | int_st_s;
    assign pierdut_s  = ~|sinc_s;
    assign deb_gata_s = sosire_s && (deb_q == DEB_ULTIM);
    assign limita_s   = ((circuit == CIRC_DREPT) && (count_q >= LAP_UNU)) ||
                        ((circuit == CIRC_CURBE) && (count_q >= LIM_CURBE));

    // next state, debounce/timeout counters, lap counter and last-side memory
    always_comb begin
        stare_d = stare_q;
        count_d = count_q;
        to_d    = {TO_W{1'b0}};
        if (sosire_s) begin
            deb_d = (deb_q == DEB_ULTIM) ? deb_q : deb_q + DEB_UNU;
        end else begin
            deb_d = {DEB_W{1'b0}};
        end
        if ((stare_q == ST_FOLLOW) || (stare_q == ST_FINISH)) begin
            if (int_dr_s && !int_st_s) begin
                parte_d = PARTE_DREAPTA;
            end else if (int_st_s && !int_dr_s) begin
                parte_d = PARTE_STANGA;
            end else begin
                parte_d = parte_q;
            end
        end else begin
            parte_d = parte_q;
        end
        case (stare_q)
            ST_IDLE: begin
                if (circuit != CIRC_IDLE) stare_d = ST_FOLLOW;
                else                      stare_d = ST_IDLE;
            end
            ST_FOLLOW: begin
                // a completed finish pattern outranks a simultaneous line loss
                if (deb_gata_s) begin
                    stare_d = ST_FINISH;
                    count_d = (count_q == LAP_PLIN) ? count_q : count_q + LAP_UNU;
                end else if (pierdut_s) begin
                    stare_d = (parte_q == PARTE_STANGA) ? ST_SEARCH_L : ST_SEARCH_R;
                end else begin
                    stare_d = ST_FOLLOW;
                end
            end
            ST_SEARCH_R, ST_SEARCH_L: begin
                to_d = (to_q == TO_ULTIM) ? to_q : to_q + TO_UNU;
                if (linie_s)                stare_d = ST_FOLLOW;
                else if (to_q == TO_ULTIM)  stare_d = ST_HALT;
                else                        stare_d = stare_q;
            end
            ST_FINISH: begin
                if (limita_s)       stare_d = ST_HALT;
                else if (!sosire_s) stare_d = ST_FOLLOW;
                else                stare_d = ST_FINISH;
            end
            ST_HALT: begin
                stare_d = ST_HALT;
            end
            default: begin
                stare_d = ST_IDLE;
            end
        endcase
        if (circuit == CIRC_IDLE) begin
            stare_d = ST_IDLE;
            count_d = {LAP_W{1'b0}};
            deb_d   = {DEB_W{1'b0}};
            to_d    = {TO_W{1'b0}};
        end else begin
            count_d = count_d;
        end
    end

    // motor directions and duty targets for the state being entered
    always_comb begin
        dir_a_d   = DIR_BRAKE;
        dir_b_d   = DIR_BRAKE;
        tinta_a_s = DC_ZERO;
        tinta_b_s = DC_ZERO;
        case (stare_d)
            ST_FOLLOW, ST_FINISH: begin
                dir_a_d = DIR_FWD;
                dir_b_d = DIR_FWD;
                if (int_dr_s && !int_st_s) begin
                    tinta_a_s = DC_INT;
                    tinta_b_s = DC_DREPT;
                end else if (int_st_s && !int_dr_s) begin
                    tinta_a_s = DC_DREPT;
                    tinta_b_s = DC_INT;
                end else begin
                    tinta_a_s = DC_DREPT;
                    tinta_b_s = DC_DREPT;
                end
            end
            ST_SEARCH_R: begin
                dir_a_d   = DIR_REV;
                dir_b_d   = DIR_FWD;
                tinta_a_s = DC_INT;
                tinta_b_s = DC_INT;
            end
            ST_SEARCH_L: begin
                dir_a_d   = DIR_FWD;
                dir_b_d   = DIR_REV;
                tinta_a_s = DC_INT;
                tinta_b_s = DC_INT;
            end
            default: begin
                dir_a_d   = DIR_BRAKE;
                dir_b_d   = DIR_BRAKE;
                tinta_a_s = DC_ZERO;
                tinta_b_s = DC_ZERO;
            end
        endcase
    end

`ifdef SOFT_START_EN
    localparam logic [DC_W-1:0] DC_PAS = DC_W'(DC_MAX / 16);

    logic [9:0] pre_q, pre_d;
    logic       pas_s;

    // rises by at most one step per tick, falls (including to zero) at once
    function automatic logic [DC_W-1:0] rampa(input logic [DC_W-1:0] actual,
                                              input logic [DC_W-1:0] tinta,
                                              input logic            pas_ok);
        if (tinta <= actual)             return tinta;
        else if (!pas_ok)                return actual;
        else if ((tinta - actual) > DC_PAS) return actual + DC_PAS;
        else                             return tinta;
    endfunction

    assign pas_s = (pre_q == 10'd1023);

    // ramp prescaler restarts while stopped so the first step lands 1024 clk after leaving IDLE
    always_comb begin
        if ((stare_d == ST_IDLE) || (stare_d == ST_HALT)) pre_d = 10'd0;
        else                                               pre_d = pre_q + 10'd1;
        dc_a_d = rampa(dc_a_q, tinta_a_s, pas_s);
        dc_b_d = rampa(dc_b_q, tinta_b_s, pas_s);
    end

    // ramp prescaler register
    always_ff @(posedge clk) begin
        if (reset) pre_q <= 10'd0;
        else       pre_q <= pre_d;
    end
`else
    // duties follow their targets directly
    always_comb begin
        dc_a_d = tinta_a_s;
        dc_b_d = tinta_b_s;
    end
`endif

    // all state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            stare_q <= ST_IDLE;
            parte_q <= PARTE_DREAPTA;
            deb_q   <= {DEB_W{1'b0}};
            to_q    <= {TO_W{1'b0}};
            count_q <= {LAP_W{1'b0}};
            dir_a_q <= DIR_BRAKE;
            dir_b_q <= DIR_BRAKE;
            dc_a_q  <= DC_ZERO;
            dc_b_q  <= DC_ZERO;
            sdr_q   <= 1'b0;
            sst_q   <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            stare_q <= stare_d;
            parte_q <= parte_d;
            deb_q   <= deb_d;
            to_q    <= to_d;
            count_q <= count_d;
            dir_a_q <= dir_a_d;
            dir_b_q <= dir_b_d;
            dc_a_q  <= dc_a_d;
            dc_b_q  <= dc_b_d;
            sdr_q   <= sinc_s[0];
            sst_q   <= sinc_s[N_SENZORI-1];
            stop_q  <= (stare_d == ST_HALT);
        end
    end

    assign directie_driverA  = dir_a_q;
    assign directie_driverB  = dir_b_q;
    assign factor_dc_driverA = dc_a_q;
    assign factor_dc_driverB = dc_b_q;
    assign semnal_dreapta    = sdr_q;
    assign semnal_stanga     = sst_q;
    assign stop              = stop_q;
    assign count_ture        = count_q;
    assign stare             = stare_q;

endmodule

// File: tb/tb_control_urmarire_linie.sv
// Directed self-checking bench for control_urmarire_linie (short debounce/timeout parameters).
module tb_control_urmarire_linie;
    import linie_pkg::*;

    localparam int N     = 5;
    localparam int DC_W  = 13;
    localparam int LAP_W = 8;
    localparam int DEB   = 16;
    localparam int STO   = 300;
    localparam int DMAX  = 2457;
    localparam int DCRB  = 1228;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     senzori;
    logic [1:0]       circuit;
    logic [1:0]       directie_driverA, directie_driverB;
    logic [DC_W-1:0]  factor_dc_driverA, factor_dc_driverB;
    logic             semnal_dreapta, semnal_stanga, stop;
    logic [LAP_W-1:0] count_ture;
    logic [2:0]       stare;

    int n_vect = 0;
    int n_err  = 0;

    always #5 clk = ~clk;

    control_urmarire_linie #(
        .N_SENZORI(N), .DC_W(DC_W), .DC_MAX(DMAX), .DC_CURBA(DCRB), .LAP_W(LAP_W),
        .DEB_CYC(DEB), .SEARCH_TO(STO), .LAP_CURBE(10)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .senzori           (senzori),
        .circuit           (circuit),
        .directie_driverA  (directie_driverA),
        .directie_driverB  (directie_driverB),
        .factor_dc_driverA (factor_dc_driverA),
        .factor_dc_driverB (factor_dc_driverB),
        .semnal_dreapta    (semnal_dreapta),
        .semnal_stanga     (semnal_stanga),
        .stop              (stop),
        .count_ture        (count_ture),
        .stare             (stare)
    );

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vect++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // duty words ramp under soft start, so the immediate values are checked only without it
    task automatic verifica_dc(input string tag, input logic [31:0] obs, input logic [31:0] exp);
`ifndef SOFT_START_EN
        verifica(tag, obs, exp);
`endif
    endtask

    task automatic tic(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic verifica_iesiri(input string tag, input stare_t st, input logic [1:0] da,
                                   input logic [1:0] db, input int dca, input int dcb);
        verifica({tag, " stare"}, 32'(stare), 32'(st));
        verifica({tag, " dirA"}, 32'(directie_driverA), 32'(da));
        verifica({tag, " dirB"}, 32'(directie_driverB), 32'(db));
        verifica_dc({tag, " dcA"}, 32'(factor_dc_driverA), 32'(dca));
        verifica_dc({tag, " dcB"}, 32'(factor_dc_driverB), 32'(dcb));
    endtask

    task automatic tura();
        senzori = 5'b10001;
        tic(DEB);
        senzori = 5'b00100;
        tic(6);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected end of run");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; circuit = 2'b00; senzori = 5'b00000;
        tic(3);
        reset = 1'b0;
        tic(1);
        verifica_iesiri("reset", ST_IDLE, 2'b00, 2'b00, 0, 0);
        verifica("reset count", 32'(count_ture), 32'd0);
        verifica("reset stop", 32'(stop), 32'd0);
        verifica("reset sdr", 32'(semnal_dreapta), 32'd0);
        verifica("reset sst", 32'(semnal_stanga), 32'd0);

`ifdef SOFT_START_EN
        senzori = 5'b00100;
        tic(3);
        circuit = 2'b01;
        tic(1);
        verifica("soft 0", 32'(factor_dc_driverA), 32'd0);
        tic(1022);
        verifica("soft pre", 32'(factor_dc_driverA), 32'd0);
        tic(1);
        verifica("soft 153", 32'(factor_dc_driverA), 32'd153);
        tic(1024);
        verifica("soft 306", 32'(factor_dc_driverB), 32'd306);
        tic(1024 * 15);
        verifica("soft max A", 32'(factor_dc_driverA), 32'd2457);
        verifica("soft max B", 32'(factor_dc_driverB), 32'd2457);
        circuit = 2'b00;
        tic(1);
        verifica("soft idle", 32'(factor_dc_driverA), 32'd0);
`endif

        circuit = 2'b01; senzori = 5'b00100;
        tic(3);
        verifica_iesiri("centru", ST_FOLLOW, 2'b01, 2'b01, DMAX, DMAX);
        senzori = 5'b00010;
        tic(3);
        verifica_iesiri("dreapta", ST_FOLLOW, 2'b01, 2'b01, DCRB, DMAX);
        senzori = 5'b00000;
        tic(3);
        verifica_iesiri("cauta_r", ST_SEARCH_R, 2'b10, 2'b01, DCRB, DCRB);
        senzori = 5'b00100;
        tic(3);
        verifica_iesiri("regasit", ST_FOLLOW, 2'b01, 2'b01, DMAX, DMAX);
        senzori = 5'b01000;
        tic(3);
        verifica_iesiri("stanga", ST_FOLLOW, 2'b01, 2'b01, DMAX, DCRB);
        senzori = 5'b00000;
        tic(3);
        verifica_iesiri("cauta_l", ST_SEARCH_L, 2'b01, 2'b10, DCRB, DCRB);
        senzori = 5'b00100;
        tic(3);

        // finish pattern one cycle too short
        senzori = 5'b10001;
        tic(3);
        verifica("sosire sdr", 32'(semnal_dreapta), 32'd1);
        verifica("sosire sst", 32'(semnal_stanga), 32'd1);
        verifica_iesiri("sosire", ST_FOLLOW, 2'b01, 2'b01, DMAX, DMAX);
        tic(DEB - 4);
        senzori = 5'b00100;
        tic(5);
        verifica("scurt count", 32'(count_ture), 32'd0);
        verifica("scurt stare", 32'(stare), 32'(ST_FOLLOW));

        // finish pattern held exactly DEB cycles, straight circuit stops after one lap
        senzori = 5'b10001;
        tic(DEB);
        verifica("deb-1 stare", 32'(stare), 32'(ST_FOLLOW));
        senzori = 5'b00100;
        tic(2);
        verifica("finish stare", 32'(stare), 32'(ST_FINISH));
        verifica("finish count", 32'(count_ture), 32'd1);
        tic(1);
        verifica_iesiri("halt01", ST_HALT, 2'b00, 2'b00, 0, 0);
        verifica("halt01 stop", 32'(stop), 32'd1);
        tic(5);
        verifica("halt ramane", 32'(stare), 32'(ST_HALT));
        circuit = 2'b00;
        tic(1);
        verifica("clear stare", 32'(stare), 32'(ST_IDLE));
        verifica("clear count", 32'(count_ture), 32'd0);
        verifica("clear stop", 32'(stop), 32'd0);

        circuit = 2'b10;
        tic(3);
        for (int i = 1; i <= 10; i++) begin
            tura();
            verifica("curbe count", 32'(count_ture), 32'(i));
            verifica("curbe stare", 32'(stare), (i < 10) ? 32'(ST_FOLLOW) : 32'(ST_HALT));
        end

        circuit = 2'b00;
        tic(1);
        verifica("clear2 count", 32'(count_ture), 32'd0);
        circuit = 2'b11;
        tic(3);
        for (int i = 1; i <= 300; i++) begin
            tura();
            verifica("andur count", 32'(count_ture), (i > 255) ? 32'd255 : 32'(i));
        end
        verifica("andur stare", 32'(stare), 32'(ST_FOLLOW));

        // search timeout boundary
        senzori = 5'b00010;
        tic(3);
        senzori = 5'b00000;
        tic(3);
        verifica("to intrare", 32'(stare), 32'(ST_SEARCH_R));
        tic(STO - 1);
        verifica("to ultim", 32'(stare), 32'(ST_SEARCH_R));
        tic(1);
        verifica_iesiri("to halt", ST_HALT, 2'b00, 2'b00, 0, 0);
        verifica("to stop", 32'(stop), 32'd1);
        circuit = 2'b00;
        tic(1);
        verifica("to clear stare", 32'(stare), 32'(ST_IDLE));
        verifica("to clear count", 32'(count_ture), 32'd0);

        // reset in the middle of a lap
        circuit = 2'b11; senzori = 5'b00100;
        tic(3);
        tura();
        tura();
        verifica("mid count", 32'(count_ture), 32'd2);
        senzori = 5'b01000;
        tic(3);
        senzori = 5'b10001;
        tic(5);
        reset = 1'b1; senzori = 5'b00000;
        tic(2);
        verifica_iesiri("mid reset", ST_IDLE, 2'b00, 2'b00, 0, 0);
        verifica("mid reset count", 32'(count_ture), 32'd0);
        verifica("mid reset sst", 32'(semnal_stanga), 32'd0);
        reset = 1'b0;
        tic(3);
        verifica("mid parte", 32'(stare), 32'(ST_SEARCH_R));

        $display("== %0d vectors applied, %0d miscompares ==", n_vect, n_err);
        $finish;
    end

endmodule
